// File: rtl/histogram_builder.sv
// Per-pixel TDC hit histogram: accumulates hits in a window, then streams
// and clears every bin for the peak detector (coarse pass, then fine pass).
module histogram_builder #(
    parameter int NB       = 6,
    parameter int PEAK_MAX = 21,
    parameter int TDC_W    = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                acq_start,
    input  logic                acq_end,
    input  logic                tdc_valid,
    input  logic [TDC_W-1:0]    tdc_code,
    input  logic [NB-1:0]       fine_base,
    output logic [PEAK_MAX-1:0] noc,
    output logic [NB-1:0]       addr,
    output logic                noc_valid,
    output logic                scan_done,
    output logic                his_num,
    output logic                busy,
    output logic                sat_flag
);

    localparam int NBINS = 1 << NB;
    localparam logic [PEAK_MAX-1:0] CMAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SCAN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [PEAK_MAX-1:0] r_hist [NBINS];
    logic [NB-1:0]       r_idx;
    logic [NB-1:0]       r_fine_base;
    logic                r_last;

    logic [NB-1:0]       w_coarse;
    logic [NB-1:0]       w_fine;
    logic [NB-1:0]       w_bin;
    logic [PEAK_MAX-1:0] w_cnt;
    logic                w_hit;
    logic                w_at_top;
    logic                w_start;

    assign w_coarse = tdc_code[TDC_W-1:NB];
    assign w_fine   = tdc_code[NB-1:0];
    assign w_bin    = his_num ? w_fine : w_coarse;
    assign w_cnt    = r_hist[w_bin];
    assign w_at_top = (w_cnt >= CMAX - PEAK_MAX'(1));
    assign w_start  = (r_state == IDLE) && acq_start;

    // Fine pass only keeps hits that fall inside the chosen coarse bin
    assign w_hit = (r_state == ACCUM) && tdc_valid &&
                   (!his_num || (w_coarse == r_fine_base));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (acq_start) begin
                    w_state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (acq_end) begin
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (r_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NBINS; i++) begin
                r_hist[i] <= '0;
            end
            r_idx       <= '0;
            r_last      <= 1'b0;
            r_fine_base <= '0;
            his_num     <= 1'b0;
            noc         <= '0;
            addr        <= '0;
            noc_valid   <= 1'b0;
            scan_done   <= 1'b0;
            busy        <= 1'b0;
            sat_flag    <= 1'b0;
        end else begin
            noc       <= '0;
            addr      <= '0;
            noc_valid <= 1'b0;
            scan_done <= 1'b0;
            busy      <= (w_state_nxt != IDLE);

            if (w_start) begin
                sat_flag <= 1'b0;
                if (his_num) begin
                    r_fine_base <= fine_base;
                end
            end

            if (w_hit) begin
                if (w_cnt != CMAX) begin
                    r_hist[w_bin] <= w_cnt + PEAK_MAX'(1);
                end
                if (w_at_top) begin
                    sat_flag <= 1'b1;
                end
            end

            // One extra SCAN cycle after the last bin emits scan_done
            if (r_state == SCAN) begin
                if (r_last) begin
                    r_last    <= 1'b0;
                    scan_done <= 1'b1;
                    his_num   <= ~his_num;
                end else begin
                    noc_valid     <= 1'b1;
                    noc           <= r_hist[r_idx];
                    addr          <= r_idx;
                    r_hist[r_idx] <= '0;
                    r_idx         <= r_idx + NB'(1);
                    if (&r_idx) begin
                        r_last <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_histogram_builder.sv
// Scoreboard bench for histogram_builder: default instance plus a
// PEAK_MAX=4 instance sharing stimulus to exercise saturation.
module tb_histogram_builder;

    localparam int NB    = 6;
    localparam int PM    = 21;
    localparam int PMS   = 4;
    localparam int TW    = 12;
    localparam int NBINS = 1 << NB;
    localparam int MAXM  = (1 << PM) - 1;
    localparam int MAXS  = (1 << PMS) - 1;

    typedef struct {
        int a;
        int c;
    } exp_t;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          acq_start = 1'b0;
    logic          acq_end   = 1'b0;
    logic          tdc_valid = 1'b0;
    logic [TW-1:0] tdc_code  = '0;
    logic [NB-1:0] fine_base = '0;

    logic [PM-1:0]  m_noc;
    logic [NB-1:0]  m_addr;
    logic           m_nv, m_sd, m_hn, m_busy, m_sat;
    logic [PMS-1:0] s_noc;
    logic [NB-1:0]  s_addr;
    logic           s_nv, s_sd, s_hn, s_busy, s_sat;

    histogram_builder #(.NB(NB), .PEAK_MAX(PM), .TDC_W(TW)) u_dut (
        .clk(clk), .reset(reset),
        .acq_start(acq_start), .acq_end(acq_end),
        .tdc_valid(tdc_valid), .tdc_code(tdc_code),
        .fine_base(fine_base),
        .noc(m_noc), .addr(m_addr), .noc_valid(m_nv),
        .scan_done(m_sd), .his_num(m_hn),
        .busy(m_busy), .sat_flag(m_sat)
    );

    histogram_builder #(.NB(NB), .PEAK_MAX(PMS), .TDC_W(TW)) u_sat (
        .clk(clk), .reset(reset),
        .acq_start(acq_start), .acq_end(acq_end),
        .tdc_valid(tdc_valid), .tdc_code(tdc_code),
        .fine_base(fine_base),
        .noc(s_noc), .addr(s_addr), .noc_valid(s_nv),
        .scan_done(s_sd), .his_num(s_hn),
        .busy(s_busy), .sat_flag(s_sat)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   mh [NBINS];
    int   m_st = 0;
    bit   m_his = 1'b0;
    int   m_fb = 0;
    bit   m_sat_m = 1'b0;
    bit   m_sat_s = 1'b0;
    int   t_end = 0;
    int   vcnt_m = 0;
    int   vcnt_s = 0;
    bit   mon_en = 1'b0;
    exp_t q_m [$];
    exp_t q_s [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, longint obs, longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon_main
        exp_t e;
        if (mon_en) begin
            if (m_nv) begin
                vcnt_m++;
                chk("q_main_nonempty", longint'(q_m.size() > 0), 1);
                if (q_m.size() > 0) begin
                    e = q_m.pop_front();
                    chk("addr_main", m_addr, e.a);
                    chk("noc_main", m_noc, e.c);
                end
            end else begin
                chk("quiet_main", {m_noc, m_addr}, 0);
            end
        end
    end

    always @(negedge clk) begin : mon_sat
        exp_t e;
        if (mon_en) begin
            if (s_nv) begin
                vcnt_s++;
                chk("q_sat_nonempty", longint'(q_s.size() > 0), 1);
                if (q_s.size() > 0) begin
                    e = q_s.pop_front();
                    chk("addr_sat", s_addr, e.a);
                    chk("noc_sat", s_noc, (e.c > MAXS) ? MAXS : e.c);
                end
            end else begin
                chk("quiet_sat", {s_noc, s_addr}, 0);
            end
        end
    end

    // One input cycle; the model follows the same accept rules
    task automatic drive(bit st, bit en, bit v, int code, int fb);
        int  c;
        int  b;
        bit  to_scan;
        exp_t e;
        to_scan   = 1'b0;
        acq_start = st;
        acq_end   = en;
        tdc_valid = v;
        tdc_code  = TW'(code);
        fine_base = NB'(fb);
        if (v && m_st == 1) begin
            c = (code >> NB) & (NBINS - 1);
            b = -1;
            if (!m_his) b = c;
            else if (c == m_fb) b = code & (NBINS - 1);
            if (b >= 0) begin
                mh[b]++;
                if (mh[b] >= MAXS) m_sat_s = 1'b1;
                if (mh[b] >= MAXM) m_sat_m = 1'b1;
            end
        end
        if (st && m_st == 0) begin
            m_st    = 1;
            m_sat_m = 1'b0;
            m_sat_s = 1'b0;
            if (m_his) m_fb = fb;
        end else if (en && m_st == 1) begin
            for (int i = 0; i < NBINS; i++) begin
                e.a = i;
                e.c = mh[i];
                q_m.push_back(e);
                q_s.push_back(e);
                mh[i] = 0;
            end
            m_st    = 2;
            vcnt_m  = 0;
            vcnt_s  = 0;
            to_scan = 1'b1;
        end
        @(posedge clk);
        #1;
        acq_start = 1'b0;
        acq_end   = 1'b0;
        tdc_valid = 1'b0;
        if (to_scan) t_end = cyc;
    endtask

    task automatic wait_scan();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (m_sd) begin
                seen = 1'b1;
                break;
            end
        end
        chk("scan_done_seen", seen, 1);
        if (seen) begin
            chk("scan_latency", cyc - t_end, NBINS + 1);
            chk("nv_count_main", vcnt_m, NBINS);
            chk("nv_count_sat", vcnt_s, NBINS);
            chk("scan_done_sat", s_sd, 1);
        end
        m_st  = 0;
        m_his = ~m_his;
        chk("his_main", m_hn, m_his);
        chk("his_sat", s_hn, m_his);
        chk("busy_off", m_busy, 0);
        chk("sat_main", m_sat, m_sat_m);
        chk("sat_small", s_sat, m_sat_s);
        chk("q_main_left", q_m.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got cyc=%0d want finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        for (int i = 0; i < NBINS; i++) mh[i] = 0;
        #2 reset = 1'b1;
        #10;
        chk("rst_nv", m_nv, 0);
        chk("rst_noc", m_noc, 0);
        chk("rst_his", m_hn, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_sat", m_sat, 0);
        chk("rst_sd", m_sd, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;

        drive(1, 0, 0, 0, 0);
        chk("busy_accum", m_busy, 1);
        repeat (3) drive(0, 0, 1, 'h2C5, 0);
        drive(0, 0, 1, 'h040, 0);
        drive(0, 1, 0, 0, 0);
        wait_scan();

        drive(1, 0, 0, 0, 11);
        repeat (2) drive(0, 0, 1, 'h2C5, 0);
        drive(0, 0, 1, 'h2C7, 0);
        repeat (5) drive(0, 0, 1, 'h040, 0);
        drive(0, 1, 0, 0, 0);
        wait_scan();

        drive(1, 0, 0, 0, 0);
        repeat (20) drive(0, 0, 1, 'h005, 0);
        drive(0, 1, 0, 0, 0);
        wait_scan();

        drive(1, 0, 0, 0, 0);
        chk("sat_clear_small", s_sat, m_sat_s);
        drive(0, 1, 0, 0, 0);
        wait_scan();

        drive(0, 0, 1, 'h800, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 'h801, 0);
        drive(0, 1, 1, 'h8C0, 0);
        repeat (3) drive(0, 0, 1, 'hFFF, 0);
        drive(1, 0, 0, 0, 0);
        wait_scan();

        drive(1, 0, 0, 0, 3);
        drive(0, 0, 1, 'h0C1, 0);
        drive(0, 1, 0, 0, 0);
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (m_nv && m_addr == 20) begin
                found = 1'b1;
                break;
            end
        end
        chk("addr20_seen", found, 1);
        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_nv", m_nv, 0);
        chk("mid_rst_addr", m_addr, 0);
        chk("mid_rst_noc", m_noc, 0);
        chk("mid_rst_busy", m_busy, 0);
        chk("mid_rst_his", m_hn, 0);
        chk("mid_rst_nv_sat", s_nv, 0);
        q_m.delete();
        q_s.delete();
        for (int i = 0; i < NBINS; i++) mh[i] = 0;
        m_st    = 0;
        m_his   = 1'b0;
        m_fb    = 0;
        m_sat_m = 1'b0;
        m_sat_s = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;

        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        wait_scan();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/histogram_builder.md
# histogram_builder

Upstream stage of the peak detector in the dToF pipeline. Accumulates TDC hit codes into an on-chip per-pixel histogram during an acquisition window, then streams every bin (address plus count) to the peak detector, clearing each bin as it is read. It runs two passes per measurement: a coarse pass over the upper TDC code bits, then a fine pass that zooms into the coarse bin chosen by the peak detector.

## Interface
- NB, 6: bin address width; histogram has 2^NB bins.
- PEAK_MAX, 21: bin count width; counts saturate at 2^PEAK_MAX-1.
- TDC_W, 12: TDC code width; must equal 2*NB.
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- acq_start  in  1  single-cycle pulse; opens an acquisition window.
- acq_end  in  1  single-cycle pulse; closes the window and starts readout.
- tdc_valid  in  1  qualifies tdc_code this cycle.
- tdc_code  in  TDC_W  TDC timestamp of one photon hit.
- fine_base  in  NB  coarse peak bin from the peak detector; sampled at acq_start of the fine pass.
- noc  out  PEAK_MAX  count of the bin being streamed.
- addr  out  NB  index of the bin being streamed.
- noc_valid  out  1  noc/addr valid this cycle.
- scan_done  out  1  single-cycle pulse after the last bin is streamed.
- his_num  out  1  pass index: 0 = coarse, 1 = fine.
- busy  out  1  high in ACCUM and SCAN.
- sat_flag  out  1  sticky; set when any bin saturates during the current pass.

## Operation
- State machine with three states:
  - IDLE: acq_start goes to ACCUM. In the fine pass, fine_base is captured into fine_base_r on the same edge. sat_flag clears on acq_start.
  - ACCUM: acq_end goes to SCAN.
  - SCAN: goes to IDLE after bin 2^NB-1 has been streamed.
- Bin selection in ACCUM:
  - Coarse pass (his_num=0): bin = tdc_code[TDC_W-1:NB]; every valid hit is accepted.
  - Fine pass (his_num=1): a hit is accepted only if tdc_code[TDC_W-1:NB] == fine_base_r; then bin = tdc_code[NB-1:0]. All other hits are dropped.
- Accumulation: an accepted hit increments its bin by 1, one hit per cycle.
  - At 2^PEAK_MAX-1 the bin holds its value (no wrap) and sat_flag sets.
- Ignored inputs:
  - tdc_valid outside ACCUM.
  - acq_start outside IDLE.
  - acq_end outside ACCUM.
- SCAN streams bins 0, 1, …, 2^NB-1, one per cycle, in ascending order with no gaps.
  - Each bin is written to zero on the same edge it is presented, so the histogram is empty after every scan.
- his_num toggles on the edge that asserts scan_done. Coarse and fine passes therefore alternate, and the 0→1 edge marks coarse-scan completion for the peak detector.
- Reset (asynchronous, any state, including mid-scan or mid-accumulation):
  - State goes to IDLE and all bins to 0.
  - his_num, noc, addr, noc_valid, scan_done, busy, sat_flag and fine_base_r go to 0.
  - No partial scan is resumed.

## Timing
- Hit latency: a hit presented at edge k is visible in its bin from edge k+1. Back-to-back hits to the same bin each count.
- acq_end and tdc_valid in the same cycle: that hit is counted. The first SCAN output appears one cycle later.
- acq_end at edge k (registered): noc_valid is high for edges k+1 … k+2^NB, with addr = 0 … 2^NB-1.
- scan_done is high for one cycle at edge k+2^NB+1; his_num toggles and busy falls on the same edge.
- noc/addr are registered outputs; noc reflects all hits accepted up to and including acq_end's cycle.
- acq_start is accepted on the cycle after scan_done at the earliest (state is IDLE then).
- Outputs hold 0 whenever noc_valid is low.
- busy is high from the edge after acq_start through the last noc_valid cycle.

## Test plan
- Reset, then coarse pass with 3 hits of code 0x2C5 and 1 hit of code 0x040, then acq_end:
  - noc_valid high for 64 consecutive cycles.
  - bin 11 = 3, bin 1 = 1, all others 0.
  - scan_done pulses one cycle after addr=63; his_num 0→1.
- Fine pass with fine_base=11, hits 0x2C5 ×2, 0x2C7 ×1 and 0x040 ×5:
  - bin 5 = 2, bin 7 = 1, all others 0 (0x040 dropped).
  - his_num 1→0.
- Saturation: PEAK_MAX=4 override, 20 hits to bin 0 → bin 0 reads 15 and sat_flag = 1. A second empty pass streams all zeros, and sat_flag clears at its acq_start.
- Boundary events:
  - tdc_valid on the same cycle as acq_end → counted.
  - tdc_valid in IDLE and during SCAN → not counted.
  - acq_start during SCAN → ignored; scan completes normally.
- Reset asserted mid-scan at addr=20:
  - Outputs go to 0 immediately.
  - A following coarse pass with zero hits streams 64 zero bins.
  - his_num starts from 0.
